// File: rtl/fluxo_dados_exp6.sv
// fluxo_dados_exp6 -- datapath for the exp6 memory game.
//
// The control unit drives the zera*/conta*/registra* strobes. This block
// returns the status flags that the control unit branches on.
//
// Contents:
//   E   : 4-bit address counter. It addresses a 16x4 sequence ROM.
//   Rod : 4-bit round counter.
//   T   : response-timeout counter. It saturates at TIMEOUT_CYCLES-1.
//   R   : 4-bit play register. It loads from the buttons.
//   A button edge detector produces a one-cycle jogada pulse per press.
//   Equality comparators produce igual, enderecoIgualRodada and fimE.
//
// Parameters:
//   TIMEOUT_CYCLES : clock cycles allowed per play before fimT.
//   N_RODADAS      : number of rounds, legal range 1..16.
//                    fimRod asserts when Rod == N_RODADAS-1.
//
// Optional feature macro: BOTOES_SYNC_EN
//   When defined, botoes passes through a 2-flop synchronizer before it
//   reaches the edge detector and R. When undefined, botoes is used directly.
//
// Ports:
//   clock, reset             : rising-edge clock; synchronous active-high reset
//   zeraE/contaE             : clear / increment E
//   zeraRod/contaRod         : clear / increment Rod
//   zeraT/contaT             : clear / increment T
//   zeraR/registraR          : clear / load R
//   botoes[3:0]              : player buttons, one-hot expected
//   fimE, fimRod, fimT       : terminal-count flags
//   jogada                   : one-cycle press pulse
//   igual                    : R matches ROM[E]
//   enderecoIgualRodada      : E == Rod
//   db_contagem, db_rodada   : debug view of E and Rod
//   db_memoria, db_jogada    : debug view of ROM[E] and R
//   db_tem_jogada            : any button pressed (after the optional sync)
module fluxo_dados_exp6 #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int N_RODADAS      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraE,
  input  logic       contaE,
  input  logic       zeraRod,
  input  logic       contaRod,
  input  logic       zeraT,
  input  logic       contaT,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic [3:0] botoes,
  output logic       fimE,
  output logic       fimRod,
  output logic       fimT,
  output logic       jogada,
  output logic       igual,
  output logic       enderecoIgualRodada,
  output logic [3:0] db_contagem,
  output logic [3:0] db_rodada,
  output logic [3:0] db_memoria,
  output logic [3:0] db_jogada,
  output logic       db_tem_jogada
);

  localparam int             T_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [T_W-1:0] T_MAX   = T_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     ROD_MAX = 4'(N_RODADAS - 1);

  // Sequence ROM. Read combinationally at address E.
  function automatic logic [3:0] rom_read(input logic [3:0] addr);
    logic [3:0] data;
    case (addr)
      4'd0:    data = 4'b0001;
      4'd1:    data = 4'b0010;
      4'd2:    data = 4'b0100;
      4'd3:    data = 4'b1000;
      4'd4:    data = 4'b0100;
      4'd5:    data = 4'b0010;
      4'd6:    data = 4'b0001;
      4'd7:    data = 4'b0001;
      4'd8:    data = 4'b0010;
      4'd9:    data = 4'b0010;
      4'd10:   data = 4'b0100;
      4'd11:   data = 4'b0100;
      4'd12:   data = 4'b1000;
      4'd13:   data = 4'b1000;
      4'd14:   data = 4'b0001;
      4'd15:   data = 4'b0100;
      default: data = 4'b0000;
    endcase
    return data;
  endfunction

  logic [3:0]     e;
  logic [3:0]     rod;
  logic [T_W-1:0] t;
  logic [3:0]     r;
  logic [3:0]     botoes_s;
  logic           tem_jogada;
  logic           tem_jogada_q;
  logic [3:0]     memoria;

`ifdef BOTOES_SYNC_EN
  logic [3:0] botoes_meta;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_meta <= 4'b0000;
      botoes_s    <= 4'b0000;
    end else begin
      botoes_meta <= botoes;
      botoes_s    <= botoes_meta;
    end
  end
`else
  assign botoes_s = botoes;
`endif

  // Address counter E: clear has priority over increment; wraps 15 -> 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      e <= 4'd0;
    end else if (zeraE) begin
      e <= 4'd0;
    end else if (contaE) begin
      e <= e + 4'd1;
    end else begin
      e <= e;
    end
  end

  // Round counter Rod: free-running wrap; the control unit stops on fimRod.
  always_ff @(posedge clock) begin
    if (reset) begin
      rod <= 4'd0;
    end else if (zeraRod) begin
      rod <= 4'd0;
    end else if (contaRod) begin
      rod <= rod + 4'd1;
    end else begin
      rod <= rod;
    end
  end

  // Timeout counter T: saturates so that fimT stays high until it is cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      t <= '0;
    end else if (zeraT) begin
      t <= '0;
    end else if (contaT && (t < T_MAX)) begin
      t <= t + T_W'(1);
    end else begin
      t <= t;
    end
  end

  // Play register R: loads the (possibly synchronized) button value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r <= 4'd0;
    end else if (zeraR) begin
      r <= 4'd0;
    end else if (registraR) begin
      r <= botoes_s;
    end else begin
      r <= r;
    end
  end

  // Previous-cycle "any button" state for the press edge detector.
  always_ff @(posedge clock) begin
    if (reset) begin
      tem_jogada_q <= 1'b0;
    end else begin
      tem_jogada_q <= tem_jogada;
    end
  end

  assign memoria    = rom_read(e);
  assign tem_jogada = |botoes_s;
  // Rising edge of "any button". A change between two non-zero codes is not a new press.
  assign jogada     = tem_jogada & ~tem_jogada_q;

  assign fimE                = (e == 4'd15);
  assign fimRod              = (rod == ROD_MAX);
  assign fimT                = (t == T_MAX);
  // ROM words are one-hot, so a multi-hot R can never match.
  assign igual               = (r == memoria);
  assign enderecoIgualRodada = (e == rod);

  assign db_contagem   = e;
  assign db_rodada     = rod;
  assign db_memoria    = memoria;
  assign db_jogada     = r;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_fluxo_dados_exp6.sv
module tb_fluxo_dados_exp6;

  // Control vector bit order: {reset, zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR}
  localparam logic [8:0] RST  = 9'b1_0000_0000;
  localparam logic [8:0] ZE   = 9'b0_1000_0000;
  localparam logic [8:0] CE   = 9'b0_0100_0000;
  localparam logic [8:0] ZROD = 9'b0_0010_0000;
  localparam logic [8:0] CROD = 9'b0_0001_0000;
  localparam logic [8:0] ZT   = 9'b0_0000_1000;
  localparam logic [8:0] CT   = 9'b0_0000_0100;
  localparam logic [8:0] ZR   = 9'b0_0000_0010;
  localparam logic [8:0] RR   = 9'b0_0000_0001;
  localparam logic [8:0] IDLE = 9'b0_0000_0000;

`ifdef BOTOES_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [3:0] e;
    logic [3:0] rod;
    logic [3:0] mem;
    logic [3:0] r;
    logic       fim_e;
    logic       fim_rod;
    logic       fim_t;
    logic       jog;
    logic       igual;
    logic       eir;
  } out_t;

  typedef struct {
    logic [8:0] ctl;
    logic [3:0] b;
    out_t       exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset, zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
  logic [3:0] botoes;
  logic       fimE, fimRod, fimT, jogada, igual, enderecoIgualRodada, db_tem_jogada;
  logic [3:0] db_contagem, db_rodada, db_memoria, db_jogada;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  out_t m_all;
  out_t m_cnt;
  out_t m_t;
  out_t m_j;
  vec_t vecs[16];
  logic [3:0] rom[16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                          4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

  fluxo_dados_exp6 #(.TIMEOUT_CYCLES(8), .N_RODADAS(4)) dut (
    .clock(clock), .reset(reset),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
    .botoes(botoes),
    .fimE(fimE), .fimRod(fimRod), .fimT(fimT), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada),
    .db_contagem(db_contagem), .db_rodada(db_rodada), .db_memoria(db_memoria),
    .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(input logic [3:0] e, input logic [3:0] rod, input logic [3:0] mem,
                              input logic [3:0] r, input logic fe, input logic fr, input logic ft,
                              input logic j, input logic ig, input logic eir);
    out_t o;
    o.e = e; o.rod = rod; o.mem = mem; o.r = r;
    o.fim_e = fe; o.fim_rod = fr; o.fim_t = ft; o.jog = j; o.igual = ig; o.eir = eir;
    return o;
  endfunction

  task automatic drive(input logic [8:0] ctl, input logic [3:0] b);
    {reset, zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR} = ctl;
    botoes = b;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic step(input logic [8:0] ctl, input logic [3:0] b, input out_t exp,
                      input out_t mask, input string name);
    out_t got;
    out_t want;
    drive(ctl, b);
    sb.push_back(exp);
    @(negedge clock);
    got = mk(db_contagem, db_rodada, db_memoria, db_jogada, fimE, fimRod, fimT,
             jogada, igual, enderecoIgualRodada);
    want = sb.pop_front();
    checks++;
    if ((got & mask) !== (want & mask)) begin
      errors++;
      $display("FAIL %s: got E=%0d Rod=%0d mem=%b R=%b fimE=%b fimRod=%b fimT=%b jog=%b igual=%b eir=%b; need E=%0d Rod=%0d mem=%b R=%b fimE=%b fimRod=%b fimT=%b jog=%b igual=%b eir=%b (mask %h)",
               name, got.e, got.rod, got.mem, got.r, got.fim_e, got.fim_rod, got.fim_t, got.jog, got.igual, got.eir,
               want.e, want.rod, want.mem, want.r, want.fim_e, want.fim_rod, want.fim_t, want.jog, want.igual, want.eir, mask);
    end
    @(posedge clock);
    #1;
  endtask

  // Apply one reset cycle. Nothing is compared during it.
  task automatic do_reset(input logic [8:0] extra);
    drive(RST | extra, 4'b0000);
    @(posedge clock);
    #1;
  endtask

  initial begin
    m_all = '1;
    m_cnt = '0; m_cnt.e = 4'hF; m_cnt.mem = 4'hF; m_cnt.fim_e = 1'b1;
    m_t   = '0; m_t.fim_t = 1'b1;
    m_j   = '0; m_j.jog = 1'b1;

    // Table: reset state, equality, register load, edge detector, round flags.
    vecs[0]  = '{IDLE,             4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[1]  = '{CE,               4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[2]  = '{CE,               4'b0000, mk(4'd1, 4'd0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[3]  = '{IDLE,             4'b0100, mk(4'd2, 4'd0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[4]  = '{RR,               4'b0100, mk(4'd2, 4'd0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[5]  = '{IDLE,             4'b0100, mk(4'd2, 4'd0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[6]  = '{RR,               4'b1000, mk(4'd2, 4'd0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[7]  = '{IDLE,             4'b0000, mk(4'd2, 4'd0, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[8]  = '{CROD,             4'b0000, mk(4'd2, 4'd0, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[9]  = '{CROD,             4'b0000, mk(4'd2, 4'd1, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[10] = '{IDLE,             4'b0000, mk(4'd2, 4'd2, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[11] = '{CROD | ZE | CE,   4'b0000, mk(4'd2, 4'd2, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[12] = '{ZR | RR,          4'b0001, mk(4'd0, 4'd3, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[13] = '{IDLE,             4'b0000, mk(4'd0, 4'd3, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[14] = '{ZROD | CROD,      4'b0000, mk(4'd0, 4'd3, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[15] = '{IDLE,             4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};

    drive(IDLE, 4'b0000);
    @(posedge clock);
    #1;
    do_reset(IDLE);
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ctl, vecs[i].b, vecs[i].exp, m_all, $sformatf("vec%0d", i));
    end

    // Address counter: full sweep, fimE only at 15, wrap, then clear beating increment.
    do_reset(IDLE);
    for (int i = 0; i < 16; i++) begin
      step(CE, 4'b0000, mk(4'(i), 4'd0, rom[i], 4'd0, (i == 15), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           m_cnt, $sformatf("sweepE%0d", i));
    end
    step(CE,      4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_cnt, "wrapE");
    step(ZE | CE, 4'b0000, mk(4'd1, 4'd0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_cnt, "preclrE");
    step(IDLE,    4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_cnt, "clrE");

    // Timeout: fimT after 7 increments, stays high, and clearing beats counting.
    do_reset(IDLE);
    for (int i = 0; i < 20; i++) begin
      step(CT, 4'b0000, mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (i >= 7), 1'b0, 1'b0, 1'b0),
           m_t, $sformatf("timeout%0d", i));
    end
    step(ZT | CT, 4'b0000, mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), m_t, "timeout_hold");
    step(IDLE,    4'b0000, mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_t, "timeout_clr");

    // Long press: one pulse only. A change 0100 -> 1000 without release gives no new pulse.
    do_reset(IDLE);
    for (int k = 0; k < 15; k++) begin
      step(IDLE, (k < 5) ? 4'b0100 : ((k < 10) ? 4'b1000 : 4'b0000),
           mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == LAT), 1'b0, 1'b0),
           m_j, $sformatf("press%0d", k));
    end

    // Round/address equality, fimRod at Rod=3, then a reset in the middle of counting.
    do_reset(IDLE);
    step(CROD, 4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), m_all, "rod0");
    step(CROD, 4'b0000, mk(4'd0, 4'd1, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "rod1");
    step(CROD, 4'b0000, mk(4'd0, 4'd2, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "rod2");
    step(CE,   4'b0000, mk(4'd0, 4'd3, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "rod3_e0");
    step(CE,   4'b0000, mk(4'd1, 4'd3, 4'b0010, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "rod3_e1");
    step(CE,   4'b0000, mk(4'd2, 4'd3, 4'b0100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "rod3_e2");
    step(IDLE, 4'b0000, mk(4'd3, 4'd3, 4'b1000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), m_all, "e_eq_rod");
    step(CE,   4'b0000, mk(4'd3, 4'd3, 4'b1000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), m_all, "e_eq_rod_hold");
    step(IDLE, 4'b0000, mk(4'd4, 4'd3, 4'b0100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), m_all, "e_ne_rod");
    do_reset(CE | CROD | CT);
    step(IDLE, 4'b0000, mk(4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), m_all, "midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
